// File: rtl/id_stage.sv
// RV32I decode stage with built-in ID/EX register: decodes OP-IMM, OP, LUI, AUIPC
// and LOAD, forwards operands from EX/MEM and stalls on load-use hazards.
module id_stage #(
    parameter int XLEN       = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_AW     = 5,
    parameter bit FWD_EX_EN  = 1'b1,
    parameter bit FWD_MEM_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       inst_i,
    input  logic [ADDR_W-1:0] instaddr_i,
    output logic [REG_AW-1:0] rs1_addr_o,
    output logic [REG_AW-1:0] rs2_addr_o,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    input  logic              ex_wen_i,
    input  logic [REG_AW-1:0] ex_wr_addr_i,
    input  logic [XLEN-1:0]   ex_wr_data_i,
    input  logic              ex_is_load_i,
    input  logic              mem_wen_i,
    input  logic [REG_AW-1:0] mem_wr_addr_i,
    input  logic [XLEN-1:0]   mem_wr_data_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] instaddr_o,
    output logic [XLEN-1:0]   op1_o,
    output logic [XLEN-1:0]   op2_o,
    output logic [3:0]        alu_op_o,
    output logic              regs_wen_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic              is_load_o,
    output logic              illegal_o
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [XLEN-1:0]   imm_i;
    logic [XLEN-1:0]   imm_u;
    logic [XLEN-1:0]   shamt;
    logic [XLEN-1:0]   pc_ext;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];
    assign rd     = REG_AW'(inst_i[11:7]);
    assign rs1    = REG_AW'(inst_i[19:15]);
    assign rs2    = REG_AW'(inst_i[24:20]);
    assign imm_i  = XLEN'($signed(inst_i[31:20]));
    assign imm_u  = XLEN'($signed({inst_i[31:12], 12'b0}));
    assign shamt  = XLEN'(inst_i[24:20]);
    assign pc_ext = XLEN'(instaddr_i);

    logic            use_rs1;
    logic            use_rs2;
    logic            dec_illegal;
    logic            dec_load;
    logic [3:0]      dec_alu;
    logic [XLEN-1:0] dec_op1;
    logic [XLEN-1:0] dec_op2;

    always_comb begin
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        dec_illegal = 1'b0;
        dec_load    = 1'b0;
        dec_alu     = ALU_ADD;
        dec_op1     = '0;
        dec_op2     = '0;
        case (opcode)
            OPC_OP_IMM: begin
                use_rs1 = 1'b1;
                dec_op2 = imm_i;
                case (funct3)
                    3'b000: dec_alu = ALU_ADD;
                    3'b010: dec_alu = ALU_SLT;
                    3'b011: dec_alu = ALU_SLTU;
                    3'b100: dec_alu = ALU_XOR;
                    3'b110: dec_alu = ALU_OR;
                    3'b111: dec_alu = ALU_AND;
                    3'b001: begin
                        dec_op2 = shamt;
                        if (funct7 == F7_BASE) dec_alu = ALU_SLL;
                        else                   dec_illegal = 1'b1;
                    end
                    default: begin
                        dec_op2 = shamt;
                        if (funct7 == F7_BASE)     dec_alu = ALU_SRL;
                        else if (funct7 == F7_ALT) dec_alu = ALU_SRA;
                        else                       dec_illegal = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  dec_alu = ALU_ADD;
                        3'b001:  dec_alu = ALU_SLL;
                        3'b010:  dec_alu = ALU_SLT;
                        3'b011:  dec_alu = ALU_SLTU;
                        3'b100:  dec_alu = ALU_XOR;
                        3'b101:  dec_alu = ALU_SRL;
                        3'b110:  dec_alu = ALU_OR;
                        default: dec_alu = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_alu = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_alu = ALU_SRA;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                dec_op2 = imm_u;
                dec_alu = ALU_PASSB;
            end
            OPC_AUIPC: begin
                dec_op1 = pc_ext;
                dec_op2 = imm_u;
            end
            OPC_LOAD: begin
                use_rs1  = 1'b1;
                dec_load = 1'b1;
                dec_op2  = imm_i;
                case (funct3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: dec_illegal = 1'b0;
                    default:                                dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
        // An illegal word travels down as an inert trap carrier: no reads, no operands.
        if (dec_illegal) begin
            use_rs1  = 1'b0;
            use_rs2  = 1'b0;
            dec_load = 1'b0;
            dec_alu  = ALU_ADD;
            dec_op1  = '0;
            dec_op2  = '0;
        end
    end

    assign rs1_addr_o = use_rs1 ? rs1 : '0;
    assign rs2_addr_o = use_rs2 ? rs2 : '0;

    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [REG_AW-1:0] a,
        input logic [XLEN-1:0]   rf,
        input logic              ex_w,
        input logic [REG_AW-1:0] ex_a,
        input logic [XLEN-1:0]   ex_d,
        input logic              mem_w,
        input logic [REG_AW-1:0] mem_a,
        input logic [XLEN-1:0]   mem_d
    );
        if (a == '0)                            return '0;
        if (FWD_EX_EN && ex_w && ex_a == a)     return ex_d;
        if (FWD_MEM_EN && mem_w && mem_a == a)  return mem_d;
        return rf;
    endfunction

    logic [XLEN-1:0] op1_nxt;
    logic [XLEN-1:0] op2_nxt;
    logic            wen_nxt;
    logic            hazard;
    logic            accept;

    assign op1_nxt = use_rs1 ? fwd_sel(rs1, rs1_data_i, ex_wen_i, ex_wr_addr_i, ex_wr_data_i,
                                       mem_wen_i, mem_wr_addr_i, mem_wr_data_i) : dec_op1;
    assign op2_nxt = use_rs2 ? fwd_sel(rs2, rs2_data_i, ex_wen_i, ex_wr_addr_i, ex_wr_data_i,
                                       mem_wen_i, mem_wr_addr_i, mem_wr_data_i) : dec_op2;
    assign wen_nxt = !dec_illegal && (rd != '0);

    // A load in EX has no data yet, so a consumer of its rd must wait one cycle.
    assign hazard = ex_is_load_i && ex_wen_i && (ex_wr_addr_i != '0) &&
                    ((use_rs1 && rs1 == ex_wr_addr_i) || (use_rs2 && rs2 == ex_wr_addr_i));

    // Handshake: a transfer happens on a clock edge where valid && ready; the producer
    // holds its payload stable while valid && !ready, and ready never waits on valid.
    assign in_ready_o = (!out_valid_o || out_ready_i) && !hazard && !flush_i;
    assign accept     = in_valid_i && in_ready_o;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_o <= 1'b0;
            inst_o      <= '0;
            instaddr_o  <= '0;
            op1_o       <= '0;
            op2_o       <= '0;
            alu_op_o    <= '0;
            regs_wen_o  <= 1'b0;
            rd_addr_o   <= '0;
            is_load_o   <= 1'b0;
            illegal_o   <= 1'b0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (accept) begin
            out_valid_o <= 1'b1;
            inst_o      <= inst_i;
            instaddr_o  <= instaddr_i;
            op1_o       <= op1_nxt;
            op2_o       <= op2_nxt;
            alu_op_o    <= dec_alu;
            regs_wen_o  <= wen_nxt;
            rd_addr_o   <= rd;
            is_load_o   <= dec_load;
            illegal_o   <= dec_illegal;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: a decode/forwarding vector table followed by
// hand-written load-use, back-pressure, flush and asynchronous-reset sequences.
module tb_id_stage;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst;
    logic [31:0] instaddr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        ex_wen;
    logic [4:0]  ex_wr_addr;
    logic [31:0] ex_wr_data;
    logic        ex_is_load;
    logic        mem_wen;
    logic [4:0]  mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] inst_q;
    logic [31:0] instaddr_q;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  alu_op;
    logic        regs_wen;
    logic [4:0]  rd_addr;
    logic        is_load;
    logic        illegal;

    id_stage dut (
        .clk(clk), .rstn(rstn),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .inst_i(inst), .instaddr_i(instaddr),
        .rs1_addr_o(rs1_addr), .rs2_addr_o(rs2_addr),
        .rs1_data_i(rs1_data), .rs2_data_i(rs2_data),
        .ex_wen_i(ex_wen), .ex_wr_addr_i(ex_wr_addr), .ex_wr_data_i(ex_wr_data),
        .ex_is_load_i(ex_is_load),
        .mem_wen_i(mem_wen), .mem_wr_addr_i(mem_wr_addr), .mem_wr_data_i(mem_wr_data),
        .flush_i(flush),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .inst_o(inst_q), .instaddr_o(instaddr_q),
        .op1_o(op1), .op2_o(op2), .alu_op_o(alu_op),
        .regs_wen_o(regs_wen), .rd_addr_o(rd_addr),
        .is_load_o(is_load), .illegal_o(illegal)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] rs1_d;
        logic [31:0] rs2_d;
        logic        ex_w;
        logic [4:0]  ex_a;
        logic [31:0] ex_d;
        logic        mem_w;
        logic [4:0]  mem_a;
        logic [31:0] mem_d;
        logic [31:0] e_op1;
        logic [31:0] e_op2;
        logic [3:0]  e_alu;
        logic        e_wen;
        logic [4:0]  e_rd;
        logic        e_load;
        logic        e_ill;
        logic [4:0]  e_ra1;
        logic [4:0]  e_ra2;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(
        input string n, input logic [31:0] i, input logic [31:0] pc,
        input logic [31:0] r1, input logic [31:0] r2,
        input logic exw, input logic [4:0] exa, input logic [31:0] exd,
        input logic mw, input logic [4:0] ma, input logic [31:0] md,
        input logic [31:0] o1, input logic [31:0] o2, input logic [3:0] alu,
        input logic w, input logic [4:0] rd, input logic ld, input logic il,
        input logic [4:0] a1, input logic [4:0] a2);
        vec_t v;
        v.name = n; v.inst = i; v.pc = pc; v.rs1_d = r1; v.rs2_d = r2;
        v.ex_w = exw; v.ex_a = exa; v.ex_d = exd;
        v.mem_w = mw; v.mem_a = ma; v.mem_d = md;
        v.e_op1 = o1; v.e_op2 = o2; v.e_alu = alu; v.e_wen = w; v.e_rd = rd;
        v.e_load = ld; v.e_ill = il; v.e_ra1 = a1; v.e_ra2 = a2;
        vecs.push_back(v);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        in_valid = 1'b0; inst = 32'h0000_0013; instaddr = '0;
        rs1_data = '0; rs2_data = '0;
        ex_wen = 1'b0; ex_wr_addr = '0; ex_wr_data = '0; ex_is_load = 1'b0;
        mem_wen = 1'b0; mem_wr_addr = '0; mem_wr_data = '0;
        flush = 1'b0; out_ready = 1'b1;
    endtask

    task automatic drive_vec(input vec_t v);
        in_valid = 1'b1; inst = v.inst; instaddr = v.pc;
        rs1_data = v.rs1_d; rs2_data = v.rs2_d;
        ex_wen = v.ex_w; ex_wr_addr = v.ex_a; ex_wr_data = v.ex_d; ex_is_load = 1'b0;
        mem_wen = v.mem_w; mem_wr_addr = v.mem_a; mem_wr_data = v.mem_d;
        flush = 1'b0; out_ready = 1'b1;
    endtask

    task automatic check_out(input vec_t v);
        chk({v.name, " out_valid"}, 32'(out_valid), 32'd1);
        chk({v.name, " op1"}, op1, exp_q.pop_front());
        chk({v.name, " op2"}, op2, v.e_op2);
        chk({v.name, " alu_op"}, 32'(alu_op), 32'(v.e_alu));
        chk({v.name, " regs_wen"}, 32'(regs_wen), 32'(v.e_wen));
        chk({v.name, " rd_addr"}, 32'(rd_addr), 32'(v.e_rd));
        chk({v.name, " is_load"}, 32'(is_load), 32'(v.e_load));
        chk({v.name, " illegal"}, 32'(illegal), 32'(v.e_ill));
        chk({v.name, " inst_o"}, inst_q, v.inst);
        chk({v.name, " instaddr_o"}, instaddr_q, v.pc);
    endtask

    // ---------------- test ----------------
    initial begin
        //      name     inst          pc     rs1_d         rs2_d    exw exa exd         mw ma mem_d        op1           op2           alu w  rd ld il ra1 ra2
        add_vec("addi",  32'hFFF00093, 32'h0, 32'hDEAD,     32'h0,   0, 0, 32'h0,      0, 0, 32'h0,       32'h0,        32'hFFFFFFFF, 0,  1, 1, 0, 0, 0, 0);
        add_vec("add_ex",32'h002081B3, 32'h4, 32'h1,        32'h7,   1, 1, 32'h5,      1, 1, 32'h9,       32'h5,        32'h7,        0,  1, 3, 0, 0, 1, 2);
        add_vec("add_mm",32'h002081B3, 32'h8, 32'h1,        32'h7,   0, 1, 32'h5,      1, 1, 32'h9,       32'h9,        32'h7,        0,  1, 3, 0, 0, 1, 2);
        add_vec("sub",   32'h402081B3, 32'hC, 32'h10,       32'h3,   0, 0, 32'h0,      0, 0, 32'h0,       32'h10,       32'h3,        1,  1, 3, 0, 0, 1, 2);
        add_vec("slli_b",32'h40109093, 32'h10,32'h55,       32'h66,  0, 0, 32'h0,      0, 0, 32'h0,       32'h0,        32'h0,        0,  0, 1, 0, 1, 0, 0);
        add_vec("srai",  32'h4030D093, 32'h14,32'h80000000, 32'h0,   0, 0, 32'h0,      0, 0, 32'h0,       32'h80000000, 32'h3,        7,  1, 1, 0, 0, 1, 0);
        add_vec("auipc", 32'h12345317, 32'h80,32'h0,        32'h0,   0, 0, 32'h0,      0, 0, 32'h0,       32'h80,       32'h12345000, 0,  1, 6, 0, 0, 0, 0);
        add_vec("nop",   32'h00000013, 32'h84,32'h0,        32'h0,   0, 0, 32'h0,      0, 0, 32'h0,       32'h0,        32'h0,        0,  0, 0, 0, 0, 0, 0);
        add_vec("lui",   32'hABCDE3B7, 32'h88,32'h0,        32'h0,   0, 0, 32'h0,      0, 0, 32'h0,       32'h0,        32'hABCDE000, 10, 1, 7, 0, 0, 0, 0);
        add_vec("lw",    32'hFFC12203, 32'h8C,32'h1000,     32'h0,   0, 0, 32'h0,      0, 0, 32'h0,       32'h1000,     32'hFFFFFFFC, 0,  1, 4, 1, 0, 2, 0);
        add_vec("ld_bad",32'h00013203, 32'h90,32'h0,        32'h0,   0, 0, 32'h0,      0, 0, 32'h0,       32'h0,        32'h0,        0,  0, 4, 0, 1, 0, 0);
        add_vec("op_bad",32'h402091B3, 32'h94,32'h0,        32'h0,   0, 0, 32'h0,      0, 0, 32'h0,       32'h0,        32'h0,        0,  0, 3, 0, 1, 0, 0);
        add_vec("sltiu", 32'h7FF0B293, 32'h98,32'h1,        32'h0,   0, 0, 32'h0,      0, 0, 32'h0,       32'h1,        32'h7FF,      4,  1, 5, 0, 0, 1, 0);
        add_vec("jal",   32'h0000006F, 32'h9C,32'h0,        32'h0,   0, 0, 32'h0,      0, 0, 32'h0,       32'h0,        32'h0,        0,  0, 0, 0, 1, 0, 0);
        add_vec("xor_x0",32'h0004C433, 32'hA0,32'h123,      32'h77,  0, 9, 32'hBAD,    1, 0, 32'h55,      32'h123,      32'h0,        5,  1, 8, 0, 0, 9, 0);
        add_vec("srl",   32'h0020D1B3, 32'hA4,32'hF0,       32'h4,   0, 0, 32'h0,      0, 0, 32'h0,       32'hF0,       32'h4,        6,  1, 3, 0, 0, 1, 2);

        drive_idle();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset alu_op", 32'(alu_op), 32'd0);
        chk("reset op2", op2, 32'd0);
        chk("reset inst_o", inst_q, 32'd0);
        chk("reset regs_wen", 32'(regs_wen), 32'd0);
        rstn = 1'b1;

        // Back-to-back table: one instruction per cycle.
        for (int i = 0; i < vecs.size(); i++) begin
            if (i > 0) check_out(vecs[i-1]);
            drive_vec(vecs[i]);
            exp_q.push_back(vecs[i].e_op1);
            #1;
            chk({vecs[i].name, " in_ready"}, 32'(in_ready), 32'd1);
            chk({vecs[i].name, " rs1_addr"}, 32'(rs1_addr), 32'(vecs[i].e_ra1));
            chk({vecs[i].name, " rs2_addr"}, 32'(rs2_addr), 32'(vecs[i].e_ra2));
            @(negedge clk);
        end
        check_out(vecs[vecs.size()-1]);

        // Load-use: LW x4 in EX, ADD x5,x4,x4 waits one cycle then takes MEM data.
        drive_idle();
        in_valid = 1'b1; inst = 32'h004202B3; instaddr = 32'h100;
        ex_is_load = 1'b1; ex_wen = 1'b1; ex_wr_addr = 5'd4; ex_wr_data = 32'hBADBAD;
        rs1_data = 32'h1111; rs2_data = 32'h2222;
        #1;
        chk("hazard in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("bubble out_valid", 32'(out_valid), 32'd0);
        ex_is_load = 1'b0; ex_wen = 1'b0;
        mem_wen = 1'b1; mem_wr_addr = 5'd4; mem_wr_data = 32'hCAFE0001;
        #1;
        chk("post-hazard in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("load-use out_valid", 32'(out_valid), 32'd1);
        chk("load-use op1", op1, 32'hCAFE0001);
        chk("load-use op2", op2, 32'hCAFE0001);
        chk("load-use rd", 32'(rd_addr), 32'd5);

        // Load into x0 is never a hazard.
        ex_is_load = 1'b1; ex_wen = 1'b1; ex_wr_addr = 5'd0;
        mem_wen = 1'b0; inst = 32'h00000293; instaddr = 32'h104;
        #1;
        chk("x0 load no hazard", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        ex_is_load = 1'b0; ex_wen = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; inst = 32'h004202B3; instaddr = 32'h108;
        mem_wen = 1'b1; mem_wr_addr = 5'd4; mem_wr_data = 32'hCAFE0001;
        @(negedge clk);

        // Back-pressure: EX stalls three cycles, a new ADDI waits.
        out_ready = 1'b0; inst = 32'hFFF00093; instaddr = 32'h10C; mem_wen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
            chk("stall out_valid", 32'(out_valid), 32'd1);
            chk("stall op1", op1, 32'hCAFE0001);
            chk("stall instaddr", instaddr_q, 32'h108);
        end

        // Flush wins over a simultaneous accept.
        out_ready = 1'b1; flush = 1'b1;
        #1;
        chk("flush in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("flushed inst dropped", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-operation, then accept in the first cycle after release.
        in_valid = 1'b1; inst = 32'hFFF00093; instaddr = 32'h200;
        @(negedge clk);
        chk("pre-reset out_valid", 32'(out_valid), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("async reset out_valid", 32'(out_valid), 32'd0);
        chk("async reset op2", op2, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        inst = 32'h4030D093; instaddr = 32'h204; rs1_data = 32'h8;
        @(negedge clk);
        chk("first accept out_valid", 32'(out_valid), 32'd1);
        chk("first accept op2", op2, 32'd3);
        chk("first accept alu_op", 32'(alu_op), 32'd7);
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain out_valid", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Registered, parametrised RV32I instruction-decode stage with the ID/EX pipeline register built in.
- Sits between the IF/ID register and EX.
- Decodes OP-IMM, OP, LUI, AUIPC and LOAD; forwards operands from EX and MEM write-back.
- Detects load-use hazards and stalls upstream; flags illegal instructions.
- Connects to EX through a valid/ready handshake with flush support.

Parameters:
XLEN, 32, data/operand width (32 only for RV32I; kept parametrised for the datapath)
ADDR_W, 32, instruction address width
REG_AW, 5, register address width
FWD_EX_EN, 1, 1 = enable forwarding from EX result
FWD_MEM_EN, 1, 1 = enable forwarding from MEM result

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
in_valid_i  in  1  IF/ID holds a valid instruction
in_ready_o  out  1  stage accepts instruction this cycle
inst_i  in  32  instruction word
instaddr_i  in  ADDR_W  instruction PC
rs1_addr_o  out  REG_AW  regfile read address 1 (combinational)
rs2_addr_o  out  REG_AW  regfile read address 2 (combinational)
rs1_data_i  in  XLEN  regfile read data 1
rs2_data_i  in  XLEN  regfile read data 2
ex_wen_i  in  1  EX will write rd
ex_wr_addr_i  in  REG_AW  EX rd
ex_wr_data_i  in  XLEN  EX result
ex_is_load_i  in  1  EX holds a load (data not yet available)
mem_wen_i  in  1  MEM will write rd
mem_wr_addr_i  in  REG_AW  MEM rd
mem_wr_data_i  in  XLEN  MEM result
flush_i  in  1  kill contents (branch/exception)
out_valid_o  out  1  ID/EX register valid
out_ready_i  in  1  EX accepts
inst_o  out  32  registered instruction
instaddr_o  out  ADDR_W  registered PC
op1_o  out  XLEN  operand 1
op2_o  out  XLEN  operand 2
alu_op_o  out  4  ALU operation code
regs_wen_o  out  1  write rd
rd_addr_o  out  REG_AW  destination register
is_load_o  out  1  LOAD instruction
illegal_o  out  1  illegal/unsupported encoding

Behaviour:
- Reset: all registered outputs are 0, including out_valid_o and alu_op_o.
- alu_op codes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
- OP-IMM (0010011): op1 = rs1; op2 = sign-extended inst[31:20].
  - Shifts use op2 = zero-extended inst[24:20].
  - SLLI/SRLI require funct7 = 0000000; SRAI requires funct7 = 0100000; any other funct7 is illegal.
- OP (0110011): op1 = rs1, op2 = rs2.
  - funct7 0000000 selects the base op; funct7 0100000 is valid only with funct3 000 (SUB) and 101 (SRA); everything else is illegal.
- LUI: op1 = 0, op2 = {inst[31:12], 12'b0}, PASSB.
- AUIPC: op1 = PC (zero-extended), op2 = {inst[31:12], 12'b0}, ADD.
- LOAD (0000011): op1 = rs1, op2 = sign-extended imm, ADD, is_load = 1. Valid funct3 values are 000, 001, 010, 100, 101; others are illegal.
- Any other opcode is illegal.
- Illegal instruction: regs_wen = 0, illegal_o = 1, operands 0, and the instruction still advances so it can trap.
- Reads: rs1_addr_o/rs2_addr_o are driven from inst_i only when the operand is used, otherwise 0.
- Forwarding priority per operand: EX (if enabled, ex_wen, addr match) > MEM (same conditions) > regfile.
  - An address of x0 never forwards and always reads 0.
- rd = 0 gives regs_wen = 0.
- Load-use hazard: ex_is_load_i && ex_wen_i && ex_wr_addr_i ≠ 0 && the address matches a used rs.
  - During a hazard, in_ready_o = 0 and a bubble is inserted (out_valid_o goes 0 once the current output is taken).
  - The hazard clears when EX advances.
- in_ready_o = (!out_valid_o || out_ready_i) && !hazard && !flush_i.
- Register update, in priority order:
  1. flush_i: out_valid_o ← 0.
  2. in_valid_i && in_ready_o: load all outputs, out_valid_o ← 1.
  3. out_ready_i: out_valid_o ← 0.
  4. Otherwise hold. Outputs are stable while out_valid_o && !out_ready_i.
- Latency: 1 cycle from acceptance to out_valid_o; throughput is 1 instruction per cycle when there is no stall.
- Reset asserted mid-operation clears immediately (async); the first acceptance is possible in the first cycle after rstn rises.

Test Plan:
- ADDI x1,x0,-1 (0xFFF00093), out_ready=1: next cycle op1=0, op2=0xFFFFFFFF, alu_op=0, rd=1, wen=1, out_valid=1.
- ADD x3,x1,x2 with ex_wen/addr=1/data=5 and mem_wen/addr=1/data=9, rs2_data=7: op1=5 (EX wins), op2=7.
- LW x4,0(x1) in EX (ex_is_load=1, addr=4), then ADD x5,x4,x4: in_ready=0 for 1 cycle, out_valid=0 in the bubble cycle, then accepted with op1=op2=mem_wr_data when the load reaches MEM.
- SLLI with funct7=0100000 (0x40109093): illegal_o=1, wen=0; SRAI x1,x1,3 (0x4030D093): op2=3, alu_op=7.
- out_ready=0 for 3 cycles with in_valid=1: outputs held, in_ready=0; flush_i pulse: out_valid=0 next cycle, and the instruction presented on the flush cycle is not accepted.
- AUIPC x6,0x12345 at PC 0x80: op1=0x80, op2=0x12345000, alu_op=0; ADDI x0,x0,0: wen=0.
